// File: rtl/cpu_press_pkg.sv
// Shared types and constants for the computer-opponent press generator.
package cpu_press_pkg;

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE, HOLDOFF} cpu_state_t;

    // Must match the LFSR instantiation width.
    localparam int CPU_WIDTH = 9;

endpackage

// File: rtl/cpu_press_gen_holdoff_timer.sv
// holdoff_timer: loadable down-counter with a zero flag, used to throttle the opponent.
module holdoff_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cpu_press_gen.sv
// cpu_press_gen: turns LFSR values and a difficulty level into single-cycle press pulses.
// Define CPU_HOLDOFF_EN to add an enforced idle period of HOLDOFF_CYCLES after each press.
module cpu_press_gen
    import cpu_press_pkg::*;
#(
    parameter int WIDTH          = CPU_WIDTH,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] rnd,
    input  logic [WIDTH-1:0] level,
    output logic             press,
    output logic             busy
);

    logic [WIDTH-1:0] rnd_q;
    logic [WIDTH-1:0] level_q;
    logic             hit_q;
    cpu_state_t       state;
    cpu_state_t       state_next;

    // Stage 1: register the decision so the FSM sees a clean, one-cycle-old hit.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rnd_q   <= '0;
            level_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            rnd_q   <= rnd;
            level_q <= level;
            hit_q   <= (level > rnd);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef CPU_HOLDOFF_EN
    localparam int CW = $clog2(HOLDOFF_CYCLES + 1);

    logic cnt_zero;

    holdoff_timer #(
        .CW(CW)
    ) u_holdoff_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (state == PRESS),
        .load_value(CW'(HOLDOFF_CYCLES - 1)),
        .dec       (state == HOLDOFF),
        .zero      (cnt_zero)
    );
`endif

    // NOTE: state_next gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable && hit_q) state_next = PRESS;
`ifdef CPU_HOLDOFF_EN
            PRESS:   state_next = enable ? HOLDOFF : IDLE;
            HOLDOFF: if (!enable || cnt_zero) state_next = IDLE;
`else
            PRESS:   state_next = enable ? RELEASE : IDLE;
            HOLDOFF: state_next = IDLE;
`endif
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        press = (state == PRESS);
        busy  = (state != IDLE);
    end

    // The registered copies always agree with the registered hit once out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (hit_q == (level_q > rnd_q) && HOLDOFF_CYCLES >= 1);
        end
    end

endmodule

// File: tb/tb_cpu_press_gen.sv
// Self-checking bench for cpu_press_gen: cycle-level reference model feeding a scoreboard queue.
module tb_cpu_press_gen;

    localparam int W   = 9;
    localparam int HC  = 4;
`ifdef CPU_HOLDOFF_EN
    localparam int GAP = HC;   // busy cycles after the press cycle
`else
    localparam int GAP = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] rnd = '0;
    logic [W-1:0] level = '0;
    logic         press;
    logic         busy;

    cpu_press_gen #(.WIDTH(W), .HOLDOFF_CYCLES(HC)) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .rnd   (rnd),
        .level (level),
        .press (press),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic press;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: a pending decision bit, a press flag and a count of remaining busy cycles.
    bit m_hit     = 0;
    bit m_pressing = 0;
    int m_rest    = 0;

    task automatic step(input bit r, input bit e, input logic [W-1:0] lv, input logic [W-1:0] rd);
        exp_t x;
        reset = r; enable = e; level = lv; rnd = rd;
        @(posedge clk);
        cycle++;
        if (r) begin
            m_hit = 0; m_pressing = 0; m_rest = 0;
        end else begin
            if (m_pressing) begin
                m_pressing = 0;
                if (!e) m_rest = 0;
            end else if (m_rest > 0) begin
                m_rest = e ? m_rest - 1 : 0;
            end else if (e && m_hit) begin
                m_pressing = 1;
                m_rest = GAP;
            end
            m_hit = (lv > rd);
        end
        x.press = m_pressing;
        x.busy  = m_pressing || (m_rest > 0);
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            if (press !== x.press || busy !== x.busy) begin
                errors++;
                $display("FAIL cycle%0d press/busy got %b/%b expected %b/%b",
                         cycle, press, busy, x.press, x.busy);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    int presses;

    initial begin
        @(negedge clk);
        // 1: reset with an always-hit input, then first press 2 cycles after release
        for (int i = 0; i < 2; i++) step(1, 1, 9'd511, 9'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 9'd511, 9'd0);
        // 2: level 0 never presses
        for (int i = 0; i < 512; i++) step(0, 1, 9'd0, W'(i));
        // 3: strict-greater hit, maximum rate
        presses = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 9'd256, 9'd255);
            if (press) presses++;
        end
        checks++;
        if (presses != 30 / (GAP + 2)) begin
            errors++;
            $display("FAIL rate_count got %0d expected %0d", presses, 30 / (GAP + 2));
        end
        // 4: equal values never hit
        for (int i = 0; i < 20; i++) step(0, 1, 9'd256, 9'd256);
        // lockup all-ones state never presses, even at top level
        for (int i = 0; i < 20; i++) step(0, 1, 9'd511, 9'd511);
        // 5: enable dropped while busy after a press
        for (int i = 0; i < 40 && !m_pressing; i++) step(0, 1, 9'd256, 9'd255);
        step(0, 1, 9'd256, 9'd255);
        for (int i = 0; i < 5; i++) step(0, 0, 9'd256, 9'd255);
        for (int i = 0; i < 12; i++) step(0, 1, 9'd256, 9'd255);
        // enable dropped exactly in the press cycle
        for (int i = 0; i < 40 && !m_pressing; i++) step(0, 1, 9'd256, 9'd255);
        step(0, 0, 9'd256, 9'd255);
        step(0, 1, 9'd256, 9'd255);
        step(0, 1, 9'd256, 9'd255);
        // 6: reset asserted while press is high
        for (int i = 0; i < 40 && !m_pressing; i++) step(0, 1, 9'd511, 9'd0);
        step(1, 1, 9'd511, 9'd0);
        for (int i = 0; i < 6; i++) step(0, 1, 9'd511, 9'd0);
        // top level with random rnd
        for (int i = 0; i < 200; i++) step(0, 1, 9'd511, W'($urandom_range(0, 511)));
        // fully random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 W'($urandom_range(0, 511)), W'($urandom_range(0, 511)));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
